// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice. in_rdy, out_vld and out_data are driven
// only from flops, so no combinational path runs from producer to consumer.
module skid_buffer #(
   parameter int unsigned  W    = 32,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         in_vld,
   input  logic [W-1:0] in_data,
   output logic         in_rdy,
   output logic         out_vld,
   output logic [W-1:0] out_data,
   input  logic         out_rdy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         push, pop;

   assign in_rdy   = (state_q != FULL);
   assign out_vld  = (state_q != EMPTY);
   assign out_data = main_q;

   assign push = in_vld & in_rdy;
   assign pop  = out_vld & out_rdy;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_d = in_data;
            end else if (push) begin
               // Consumer stalled: the in-flight beat lands in skid, main keeps the oldest
               state_d = FULL;
               skid_d  = in_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= EMPTY;
         main_q  <= INIT;
         skid_q  <= INIT;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   a_no_push_full : assert property (@(posedge clk) disable iff (srst)
      (state_q == FULL) |-> !push);
   a_no_pop_empty : assert property (@(posedge clk) disable iff (srst)
      (state_q == EMPTY) |-> !pop);
   a_out_stable   : assert property (@(posedge clk) disable iff (srst)
      (out_vld && !out_rdy) |=> $stable(out_data));

endmodule
